// File: rtl/mul_arbiter.sv
// Arbitrates NREQ requesters onto one shared multiplier; round-robin, or fixed priority with MUL_ARB_FIXED_PRIO_EN.
// Latency: grant -> rsp_valid after MUL_LAT+1 clocks; one job in flight, next grant in the IDLE cycle after the response.
// Backpressure: rsp_valid/rsp_c/rsp_id hold until rsp_ready; req_ready stays low until the response is accepted.
module mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_id,
    output logic [31:0]          rsp_c,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [31:0]          mul_c
);

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  id;
    } job_t;

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    job_t            job_q, job_d;
    logic [31:0]     rsp_c_q, rsp_c_d;
    logic            arm_q, arm_d;
`ifndef MUL_ARB_FIXED_PRIO_EN
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW:0]     sum;
`endif

    logic            found;
    logic            fire;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt_oh;
    logic [15:0]     a_sel, b_sel;

    // Search order: index 0 upward for fixed priority, otherwise from the pointer with wrap.
    always_comb begin
        found   = 1'b0;
        idx     = '0;
        gnt_idx = '0;
        gnt_oh  = '0;
        a_sel   = '0;
        b_sel   = '0;
`ifndef MUL_ARB_FIXED_PRIO_EN
        sum     = '0;
`endif
        for (int k = 0; k < NREQ; k++) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
            idx = IW'(k);
`else
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            idx = sum[IW-1:0];
`endif
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                gnt_idx     = idx;
                gnt_oh[idx] = 1'b1;
                a_sel       = req_a[{idx, 4'b0000} +: 16];
                b_sel       = req_b[{idx, 4'b0000} +: 16];
            end
        end
    end

    // arm_q keeps req_ready low in the cycle reset is released.
    assign fire      = arm_q && (state_q == ST_IDLE) && found;
    assign req_ready = fire ? gnt_oh : '0;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = job_q.id;
    assign rsp_c     = rsp_c_q;
    assign mul_a     = job_q.a;
    assign mul_b     = job_q.b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        job_d   = job_q;
        rsp_c_d = rsp_c_q;
        arm_d   = 1'b1;
`ifndef MUL_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    state_d  = ST_WAIT;
                    cnt_d    = 4'(MUL_LAT);
                    job_d.a  = a_sel;
                    job_d.b  = b_sel;
                    job_d.id = 3'(gnt_idx);
`ifndef MUL_ARB_FIXED_PRIO_EN
                    ptr_d    = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
`endif
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_c_d = mul_c;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            job_q   <= '0;
            rsp_c_q <= '0;
            arm_q   <= 1'b0;
`ifndef MUL_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            job_q   <= job_d;
            rsp_c_q <= rsp_c_d;
            arm_q   <= arm_d;
`ifndef MUL_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule
